mem_dcache_ctrl: RTL and testbench
==================================

// Module: mem_dcache_ctrl
// PURPOSE
//  MEM-stage front end directly downstream of the EXE stage.
//  - Latches the EXE->MEM bundle: address, byte-enables, store data, load type, Dst, exception.
//  - Drives an SRAM-like req/addr_ok/data_ok handshake to the DCache.
//  - Stalls the pipe until the access completes.
//  - Aligns and extends load data into MEM_Result; that result also feeds the EXE forwarding mux.
// PARAMETERS
//  UC_SEG   3'b101  addr[31:29] value marking kseg1 (uncached); drives dreq_uncached
//  HOLD_EN  1       1: buffer returned load data while MEM_Wr=0; 0: MEM_Wr=0 during an access is illegal
// PORTS
//  clk                 in   1   clock; one clock domain
//  rst                 in   1   synchronous, active-high reset
//  MEM_Flush           in   1   kill the MEM slot (exception/ERET)
//  MEM_Wr              in   1   MEM register write enable (0 = downstream stall)
//  EXE_ALUOut          in   32  effective address / ALU result
//  EXE_DCache_Wen      in   4   store byte enables (0 = not a store)
//  EXE_DataToDcache    in   32  lane-aligned store data
//  EXE_LoadType        in   LoadType  load kind (LD_NONE for non-loads)
//  EXE_Dst             in   5   destination register
//  EXE_RegsWrType      in   RegsWrType  write-back enables
//  EXE_ExceptType_final in  ExceptinPipeType  exceptions raised up to EXE
//  dreq_valid          out  1   DCache request valid
//  dreq_wen            out  4   request byte enables
//  dreq_addr           out  32  request address (word aligned for loads, [1:0] kept for stores)
//  dreq_wdata          out  32  request store data
//  dreq_uncached       out  1   addr[31:29]==UC_SEG
//  dreq_addr_ok        in   1   DCache accepted the request this cycle
//  dreq_data_ok        in   1   DCache returned data / write done this cycle
//  dreq_rdata          in   32  read data (valid with data_ok)
//  MEM_Result          out  32  extended load data, or the latched ALUOut
//  MEM_Dst             out  5   latched Dst
//  MEM_RegsWrType      out  RegsWrType  latched enables; zeroed when the slot is invalid
//  MEM_ExceptType      out  ExceptinPipeType  latched exception
//  MEM_Stall           out  1   memory access in MEM not yet complete
// BEHAVIOUR
//  Reset:
//  - all MEM_* regs 0, slot invalid, state IDLE.
//  - dreq_valid=0, MEM_Stall=0, MEM_Result=0.
//  Pipeline register:
//  - Captures EXE_* when MEM_Wr=1 and MEM_Stall=0.
//  - MEM_Flush=1 (priority over MEM_Wr) clears valid and RegsWrType.
//  Memory op: valid & (LoadType!=LD_NONE | Wen!=0) & no exception in MEM_ExceptType.
//  FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
//  - IDLE: a memory op in the slot -> REQ in the same cycle; dreq_valid is combinational from the slot.
//  - REQ: dreq_valid=1 and dreq_* held stable until addr_ok.
//    - addr_ok & data_ok in the same cycle -> done.
//    - addr_ok alone -> WAIT.
//  - WAIT: dreq_valid=0; data_ok -> done.
//  - Done: if MEM_Wr=1 -> IDLE; else (HOLD_EN) rdata is latched -> HOLD.
//  - HOLD: stays until MEM_Wr=1, then IDLE. MEM_Stall=0 in HOLD; the stall comes from downstream.
//  - MEM_Stall=1 in REQ and in WAIT without data_ok. It drops in the data_ok cycle.
//  - Min latency: addr_ok in the request cycle and data_ok the next cycle = 2 cycles.
//  Flush mid-access:
//  - In REQ before addr_ok: drop dreq_valid next cycle -> IDLE.
//  - In WAIT: -> DRAIN. Swallow exactly one data_ok and discard it. No new req issues until then.
//  - MEM_Stall stays 0 for the flushed slot.
//  - A new op captured during DRAIN waits in the slot; MEM_Stall=1 until its own access completes.
//  Load extension (addr[1:0]=a, data = HOLD reg or rdata):
//  - LB/LBU: byte lane a, sign- or zero-extended.
//  - LH/LHU: half lane a[1], sign- or zero-extended.
//  - LW: full word.
//  - Non-loads: latched ALUOut.
//  Misaligned addresses are already flagged in EXE. Those ops never issue.
//  Reset mid-access: immediately IDLE. An outstanding data_ok after reset is ignored.
// STRUCTURE
//  - Shared package (CPU_Defines): LoadType enum {LD_NONE,LB,LBU,LH,LHU,LW}; state enum; UC_SEG constant.
//  - Sub-module load_align: combinational lane select and extend (LoadType, addr[1:0], data) -> 32b.
//  - FSM and regs stay in this module.
// TESTING
//  1 LW 0x8000_0010; addr_ok in cycle 0, data_ok in cycle 1, rdata=0x1234_5678
//    -> MEM_Stall high 1 cycle, MEM_Result=0x1234_5678, dreq_uncached=0.
//  2 LB addr ..03, rdata=0x80FF_0000 -> 0xFFFF_FF80.
//    LBU -> 0x0000_0080. LH addr ..02 -> 0xFFFF_80FF.
//  3 SW to 0xA000_0000, Wen=4'hF, addr_ok held low 3 cycles
//    -> dreq_* stable for 4 cycles, dreq_uncached=1, then stall released on data_ok.
//  4 Flush while in WAIT; data_ok arrives 2 cycles later
//    -> DRAIN swallows it. The next load's req issues only after that. No write-back of the flushed Dst.
//  5 data_ok while MEM_Wr=0 for 3 cycles -> HOLD keeps rdata; MEM_Result correct when MEM_Wr rises.
//  6 rst asserted in REQ -> next cycle dreq_valid=0, MEM_Stall=0, MEM_RegsWrType=0.

Source files
------------

// File: rtl/mem_dcache_ctrl_pkg.sv
// Shared CPU definitions: load kinds, write-back enables, exception bundle,
// MEM-stage FSM encodings and the uncached segment marker.
package CPU_Defines;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LB      = 3'd1,
        LBU     = 3'd2,
        LH      = 3'd3,
        LHU     = 3'd4,
        LW      = 3'd5
    } LoadType;

    typedef struct packed {
        logic HIWr;
        logic LOWr;
        logic CP0Wr;
        logic RFWr;
    } RegsWrType;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic ReservedInstruction;
        logic Syscall;
        logic Break;
        logic Eret;
        logic WrWrongAddressinMEM;
        logic RdWrongAddressinMEM;
        logic Overflow;
    } ExceptinPipeType;

    localparam logic [2:0] UC_SEG = 3'b101;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    function automatic logic hasExcept(input ExceptinPipeType e);
        return |e;
    endfunction

endpackage

// File: rtl/mem_dcache_ctrl_load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
    import CPU_Defines::*;
(
    input  LoadType     loadType_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel  = 8'h00;
        halfSel  = 16'h0000;
        result_o = 32'h0000_0000;
        case (offset_i)
            2'd0: byteSel = data_i[7:0];
            2'd1: byteSel = data_i[15:8];
            2'd2: byteSel = data_i[23:16];
            2'd3: byteSel = data_i[31:24];
        endcase
        halfSel = offset_i[1] ? data_i[31:16] : data_i[15:0];
        case (loadType_i)
            LB:      result_o = {{24{byteSel[7]}}, byteSel};
            LBU:     result_o = {24'h000000, byteSel};
            LH:      result_o = {{16{halfSel[15]}}, halfSel};
            LHU:     result_o = {16'h0000, halfSel};
            LW:      result_o = data_i;
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_dcache_ctrl.sv
// MEM-stage front end: latches the EXE bundle, runs the DCache req/addr_ok/data_ok
// handshake, stalls the pipe during the access and aligns returned load data.
module mem_dcache_ctrl
    import CPU_Defines::*;
#(
    parameter logic [2:0] UC_SEG  = CPU_Defines::UC_SEG,
    parameter bit         HOLD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEM_Flush,
    input  logic            MEM_Wr,
    input  logic [31:0]     EXE_ALUOut,
    input  logic [3:0]      EXE_DCache_Wen,
    input  logic [31:0]     EXE_DataToDcache,
    input  LoadType         EXE_LoadType,
    input  logic [4:0]      EXE_Dst,
    input  RegsWrType       EXE_RegsWrType,
    input  ExceptinPipeType EXE_ExceptType_final,
    output logic            dreq_valid,
    output logic [3:0]      dreq_wen,
    output logic [31:0]     dreq_addr,
    output logic [31:0]     dreq_wdata,
    output logic            dreq_uncached,
    input  logic            dreq_addr_ok,
    input  logic            dreq_data_ok,
    input  logic [31:0]     dreq_rdata,
    output logic [31:0]     MEM_Result,
    output logic [4:0]      MEM_Dst,
    output RegsWrType       MEM_RegsWrType,
    output ExceptinPipeType MEM_ExceptType,
    output logic            MEM_Stall
);

    logic            slotValid_q;
    logic [31:0]     aluOut_q;
    logic [3:0]      wen_q;
    logic [31:0]     wdata_q;
    LoadType         loadType_q;
    logic [4:0]      dst_q;
    RegsWrType       regsWr_q;
    ExceptinPipeType except_q;

    logic [2:0]      state_q, state_d;
    logic [31:0]     holdData_q, holdData_d;

    logic            memOp;
    logic            issuing;
    logic            accessDone;
    logic            capture;
    logic [31:0]     alignData;
    logic [31:0]     loadResult;

    assign memOp   = slotValid_q & ((loadType_q != LD_NONE) | (wen_q != 4'h0))
                   & ~hasExcept(except_q);
    // An unissued op sitting in the slot while IDLE behaves exactly like REQ.
    assign issuing = (state_q == S_REQ) | ((state_q == S_IDLE) & memOp);

    assign MEM_Stall = ~MEM_Flush
                     & ((issuing & ~(dreq_addr_ok & dreq_data_ok))
                      | ((state_q == S_WAIT) & ~dreq_data_ok)
                      | ((state_q == S_DRAIN) & memOp));

    assign capture = MEM_Wr & ~MEM_Stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            slotValid_q <= 1'b0;
            aluOut_q    <= 32'h0000_0000;
            wen_q       <= 4'h0;
            wdata_q     <= 32'h0000_0000;
            loadType_q  <= LD_NONE;
            dst_q       <= 5'd0;
            regsWr_q    <= '0;
            except_q    <= '0;
        end else if (MEM_Flush) begin
            slotValid_q <= 1'b0;
            regsWr_q    <= '0;
        end else if (capture) begin
            slotValid_q <= 1'b1;
            aluOut_q    <= EXE_ALUOut;
            wen_q       <= EXE_DCache_Wen;
            wdata_q     <= EXE_DataToDcache;
            loadType_q  <= EXE_LoadType;
            dst_q       <= EXE_Dst;
            regsWr_q    <= EXE_RegsWrType;
            except_q    <= EXE_ExceptType_final;
        end
    end

    // A flush after addr_ok leaves one data_ok in flight; DRAIN eats it before any new request.
    always_comb begin
        state_d    = state_q;
        holdData_d = holdData_q;
        accessDone = 1'b0;
        case (state_q)
            S_IDLE, S_REQ: begin
                if (issuing) begin
                    if (MEM_Flush) begin
                        state_d = (dreq_addr_ok & ~dreq_data_ok) ? S_DRAIN : S_IDLE;
                    end else if (dreq_addr_ok & dreq_data_ok) begin
                        accessDone = 1'b1;
                    end else if (dreq_addr_ok) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (MEM_Flush) begin
                    state_d = dreq_data_ok ? S_IDLE : S_DRAIN;
                end else if (dreq_data_ok) begin
                    accessDone = 1'b1;
                end
            end
            S_HOLD: begin
                if (MEM_Flush | MEM_Wr) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dreq_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accessDone) begin
            if (MEM_Wr) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_HOLD;
                if (HOLD_EN) begin
                    holdData_d = dreq_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            holdData_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            holdData_q <= holdData_d;
        end
    end

    assign dreq_valid    = issuing;
    assign dreq_wen      = wen_q;
    assign dreq_wdata    = wdata_q;
    assign dreq_addr     = (loadType_q != LD_NONE) ? {aluOut_q[31:2], 2'b00} : aluOut_q;
    assign dreq_uncached = (aluOut_q[31:29] == UC_SEG);

    assign alignData = (state_q == S_HOLD) ? holdData_q : dreq_rdata;

    load_align u_load_align (
        .loadType_i (loadType_q),
        .offset_i   (aluOut_q[1:0]),
        .data_i     (alignData),
        .result_o   (loadResult)
    );

    assign MEM_Result     = (loadType_q == LD_NONE) ? aluOut_q : loadResult;
    assign MEM_Dst        = dst_q;
    assign MEM_RegsWrType = slotValid_q ? regsWr_q : '0;
    assign MEM_ExceptType = except_q;

endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// Directed bench for mem_dcache_ctrl: a scripted DCache responder, a queue of
// expected MEM_Result values and immediate assertions at every check point.
module tb_mem_dcache_ctrl;
    import CPU_Defines::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            MEM_Flush;
    logic            MEM_Wr;
    logic [31:0]     EXE_ALUOut;
    logic [3:0]      EXE_DCache_Wen;
    logic [31:0]     EXE_DataToDcache;
    LoadType         EXE_LoadType;
    logic [4:0]      EXE_Dst;
    RegsWrType       EXE_RegsWrType;
    ExceptinPipeType EXE_ExceptType_final;
    logic            dreq_valid;
    logic [3:0]      dreq_wen;
    logic [31:0]     dreq_addr;
    logic [31:0]     dreq_wdata;
    logic            dreq_uncached;
    logic            dreq_addr_ok;
    logic            dreq_data_ok;
    logic [31:0]     dreq_rdata;
    logic [31:0]     MEM_Result;
    logic [4:0]      MEM_Dst;
    RegsWrType       MEM_RegsWrType;
    ExceptinPipeType MEM_ExceptType;
    logic            MEM_Stall;

    int assertCount = 0;
    int failCount   = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    mem_dcache_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .MEM_Flush            (MEM_Flush),
        .MEM_Wr               (MEM_Wr),
        .EXE_ALUOut           (EXE_ALUOut),
        .EXE_DCache_Wen       (EXE_DCache_Wen),
        .EXE_DataToDcache     (EXE_DataToDcache),
        .EXE_LoadType         (EXE_LoadType),
        .EXE_Dst              (EXE_Dst),
        .EXE_RegsWrType       (EXE_RegsWrType),
        .EXE_ExceptType_final (EXE_ExceptType_final),
        .dreq_valid           (dreq_valid),
        .dreq_wen             (dreq_wen),
        .dreq_addr            (dreq_addr),
        .dreq_wdata           (dreq_wdata),
        .dreq_uncached        (dreq_uncached),
        .dreq_addr_ok         (dreq_addr_ok),
        .dreq_data_ok         (dreq_data_ok),
        .dreq_rdata           (dreq_rdata),
        .MEM_Result           (MEM_Result),
        .MEM_Dst              (MEM_Dst),
        .MEM_RegsWrType       (MEM_RegsWrType),
        .MEM_ExceptType       (MEM_ExceptType),
        .MEM_Stall            (MEM_Stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag);
        logic [31:0] e;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected <scoreboard empty>", tag, MEM_Result);
        end else begin
            e = expQ.pop_front();
            checkOutput(tag, MEM_Result, e);
        end
    endtask

    task automatic clearExe();
        EXE_ALUOut           = 32'h0;
        EXE_DCache_Wen       = 4'h0;
        EXE_DataToDcache     = 32'h0;
        EXE_LoadType         = LD_NONE;
        EXE_Dst              = 5'd0;
        EXE_RegsWrType       = '0;
        EXE_ExceptType_final = '0;
    endtask

    task automatic applyStimulus(input LoadType lt, input logic [3:0] wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] dst,
                                 input RegsWrType rw, input ExceptinPipeType ex);
        EXE_LoadType         = lt;
        EXE_DCache_Wen       = wen;
        EXE_ALUOut           = addr;
        EXE_DataToDcache     = wdata;
        EXE_Dst              = dst;
        EXE_RegsWrType       = rw;
        EXE_ExceptType_final = ex;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Op enters the slot, addr_ok on the issue cycle, data_ok on the next.
    task automatic doAccess(input string tag, input LoadType lt, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [31:0] expReqAddr,
                            input logic [31:0] expResult);
        applyStimulus(lt, wen, addr, wdata, 5'd3, RegsWrType'(4'b0001), '0);
        expQ.push_back(expResult);
        nextCycle();
        clearExe();
        dreq_addr_ok = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".valid"}, 32'(dreq_valid), 32'd1);
        checkOutput({tag, ".addr"}, dreq_addr, expReqAddr);
        nextCycle();
        dreq_addr_ok = 1'b0;
        dreq_data_ok = 1'b1;
        dreq_rdata   = rdata;
        @(negedge clk);
        checkOutput({tag, ".stall"}, 32'(MEM_Stall), 32'd0);
        checkResult({tag, ".result"});
        nextCycle();
        dreq_data_ok = 1'b0;
        dreq_rdata   = 32'h0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected $finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        MEM_Flush    = 1'b0;
        MEM_Wr       = 1'b1;
        dreq_addr_ok = 1'b0;
        dreq_data_ok = 1'b0;
        dreq_rdata   = 32'h0;
        clearExe();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst.valid", 32'(dreq_valid), 32'd0);
        checkOutput("rst.stall", 32'(MEM_Stall), 32'd0);
        checkOutput("rst.result", MEM_Result, 32'h0);
        checkOutput("rst.regswr", 32'(MEM_RegsWrType), 32'h0);
        checkOutput("rst.dst", 32'(MEM_Dst), 32'h0);
        nextCycle();

        // Test 1: LW, minimum two-cycle latency, cached segment
        applyStimulus(LW, 4'h0, 32'h8000_0010, 32'h0, 5'd5, RegsWrType'(4'b0001), '0);
        expQ.push_back(32'h1234_5678);
        nextCycle();
        clearExe();
        dreq_addr_ok = 1'b1;
        @(negedge clk);
        checkOutput("t1.valid", 32'(dreq_valid), 32'd1);
        checkOutput("t1.addr", dreq_addr, 32'h8000_0010);
        checkOutput("t1.uncached", 32'(dreq_uncached), 32'd0);
        checkOutput("t1.stallIssue", 32'(MEM_Stall), 32'd1);
        nextCycle();
        dreq_addr_ok = 1'b0;
        dreq_data_ok = 1'b1;
        dreq_rdata   = 32'h1234_5678;
        @(negedge clk);
        checkOutput("t1.stallDone", 32'(MEM_Stall), 32'd0);
        checkOutput("t1.validWait", 32'(dreq_valid), 32'd0);
        checkResult("t1.result");
        checkOutput("t1.dst", 32'(MEM_Dst), 32'd5);
        checkOutput("t1.regswr", 32'(MEM_RegsWrType), 32'h1);
        nextCycle();
        dreq_data_ok = 1'b0;
        dreq_rdata   = 32'h0;
        @(negedge clk);
        checkOutput("t1.stallAfter", 32'(MEM_Stall), 32'd0);
        nextCycle();

        // Test 2: lane select and extension
        doAccess("t2.lb3",  LB,  4'h0, 32'h0000_0003, 32'h0, 32'h80FF_0000, 32'h0000_0000, 32'hFFFF_FF80);
        doAccess("t2.lbu3", LBU, 4'h0, 32'h0000_0003, 32'h0, 32'h80FF_0000, 32'h0000_0000, 32'h0000_0080);
        doAccess("t2.lh2",  LH,  4'h0, 32'h0000_0002, 32'h0, 32'h80FF_0000, 32'h0000_0000, 32'hFFFF_80FF);
        doAccess("t2.lhu2", LHU, 4'h0, 32'h0000_0002, 32'h0, 32'h80FF_0000, 32'h0000_0000, 32'h0000_80FF);
        doAccess("t2.lb2",  LB,  4'h0, 32'h0000_0006, 32'h0, 32'h80FF_0000, 32'h0000_0004, 32'hFFFF_FFFF);
        doAccess("t2.lh0",  LH,  4'h0, 32'h0000_0008, 32'h0, 32'h80FF_7FFE, 32'h0000_0008, 32'h0000_7FFE);
        doAccess("t2.sb3",  LD_NONE, 4'b1000, 32'hA000_0003, 32'h5500_0000, 32'h0, 32'hA000_0003, 32'hA000_0003);

        // Test 3: uncached SW with addr_ok held low for three cycles
        applyStimulus(LD_NONE, 4'hF, 32'hA000_0000, 32'hDEAD_BEEF, 5'd0, '0, '0);
        expQ.push_back(32'hA000_0000);
        nextCycle();
        clearExe();
        for (int i = 0; i < 4; i++) begin
            dreq_addr_ok = (i == 3);
            @(negedge clk);
            checkOutput($sformatf("t3.valid%0d", i), 32'(dreq_valid), 32'd1);
            checkOutput($sformatf("t3.addr%0d", i), dreq_addr, 32'hA000_0000);
            checkOutput($sformatf("t3.wen%0d", i), 32'(dreq_wen), 32'hF);
            checkOutput($sformatf("t3.wdata%0d", i), dreq_wdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("t3.uncached%0d", i), 32'(dreq_uncached), 32'd1);
            checkOutput($sformatf("t3.stall%0d", i), 32'(MEM_Stall), 32'd1);
            nextCycle();
        end
        dreq_addr_ok = 1'b0;
        @(negedge clk);
        checkOutput("t3.waitStall", 32'(MEM_Stall), 32'd1);
        checkOutput("t3.waitValid", 32'(dreq_valid), 32'd0);
        nextCycle();
        dreq_data_ok = 1'b1;
        @(negedge clk);
        checkOutput("t3.doneStall", 32'(MEM_Stall), 32'd0);
        checkResult("t3.result");
        nextCycle();
        dreq_data_ok = 1'b0;

        // Test 4: flush in WAIT, stray data_ok two cycles later is drained
        applyStimulus(LW, 4'h0, 32'h0000_0100, 32'h0, 5'd7, RegsWrType'(4'b0001), '0);
        nextCycle();
        clearExe();
        dreq_addr_ok = 1'b1;
        @(negedge clk);
        checkOutput("t4.valid", 32'(dreq_valid), 32'd1);
        nextCycle();
        dreq_addr_ok = 1'b0;
        MEM_Flush    = 1'b1;
        @(negedge clk);
        checkOutput("t4.flushStall", 32'(MEM_Stall), 32'd0);
        nextCycle();
        MEM_Flush = 1'b0;
        applyStimulus(LW, 4'h0, 32'h0000_0200, 32'h0, 5'd9, RegsWrType'(4'b0001), '0);
        expQ.push_back(32'h55AA_55AA);
        @(negedge clk);
        checkOutput("t4.noWb", 32'(MEM_RegsWrType), 32'h0);
        checkOutput("t4.drainValid", 32'(dreq_valid), 32'd0);
        checkOutput("t4.drainStall", 32'(MEM_Stall), 32'd0);
        nextCycle();
        clearExe();
        dreq_data_ok = 1'b1;
        dreq_rdata   = 32'hBAD0_BAD0;
        @(negedge clk);
        checkOutput("t4.heldNoReq", 32'(dreq_valid), 32'd0);
        checkOutput("t4.heldStall", 32'(MEM_Stall), 32'd1);
        checkOutput("t4.newDst", 32'(MEM_Dst), 32'd9);
        nextCycle();
        dreq_data_ok = 1'b0;
        dreq_addr_ok = 1'b1;
        @(negedge clk);
        checkOutput("t4.reqValid", 32'(dreq_valid), 32'd1);
        checkOutput("t4.reqAddr", dreq_addr, 32'h0000_0200);
        nextCycle();
        dreq_addr_ok = 1'b0;
        dreq_data_ok = 1'b1;
        dreq_rdata   = 32'h55AA_55AA;
        @(negedge clk);
        checkOutput("t4.doneStall", 32'(MEM_Stall), 32'd0);
        checkResult("t4.result");
        nextCycle();
        dreq_data_ok = 1'b0;
        dreq_rdata   = 32'h0;

        // Test 5: data returned while downstream is stalled
        applyStimulus(LHU, 4'h0, 32'h0000_0302, 32'h0, 5'd4, RegsWrType'(4'b0001), '0);
        expQ.push_back(32'h0000_CAFE);
        nextCycle();
        clearExe();
        dreq_addr_ok = 1'b1;
        nextCycle();
        dreq_addr_ok = 1'b0;
        dreq_data_ok = 1'b1;
        dreq_rdata   = 32'hCAFE_F00D;
        MEM_Wr       = 1'b0;
        @(negedge clk);
        checkOutput("t5.doneStall", 32'(MEM_Stall), 32'd0);
        nextCycle();
        dreq_data_ok = 1'b0;
        dreq_rdata   = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5.holdStall%0d", i), 32'(MEM_Stall), 32'd0);
            checkOutput($sformatf("t5.holdResult%0d", i), MEM_Result, 32'h0000_CAFE);
            nextCycle();
        end
        MEM_Wr = 1'b1;
        @(negedge clk);
        checkResult("t5.result");
        nextCycle();
        dreq_rdata = 32'h0;

        // Excepting op never issues
        applyStimulus(LW, 4'h0, 32'h0000_0501, 32'h0, 5'd2, RegsWrType'(4'b0001),
                      ExceptinPipeType'(9'h002));
        nextCycle();
        clearExe();
        @(negedge clk);
        checkOutput("exc.valid", 32'(dreq_valid), 32'd0);
        checkOutput("exc.stall", 32'(MEM_Stall), 32'd0);
        checkOutput("exc.type", 32'(MEM_ExceptType), 32'h002);
        nextCycle();

        // Test 6: reset while in REQ, stale data_ok afterwards ignored
        applyStimulus(LW, 4'h0, 32'h0000_0400, 32'h0, 5'd6, RegsWrType'(4'b0001), '0);
        nextCycle();
        clearExe();
        @(negedge clk);
        checkOutput("t6.valid", 32'(dreq_valid), 32'd1);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6.reqStall", 32'(MEM_Stall), 32'd1);
        nextCycle();
        rst          = 1'b0;
        dreq_data_ok = 1'b1;
        @(negedge clk);
        checkOutput("t6.valid0", 32'(dreq_valid), 32'd0);
        checkOutput("t6.stall0", 32'(MEM_Stall), 32'd0);
        checkOutput("t6.regswr0", 32'(MEM_RegsWrType), 32'h0);
        nextCycle();
        dreq_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("t6.valid1", 32'(dreq_valid), 32'd0);
        checkOutput("t6.stall1", 32'(MEM_Stall), 32'd0);
        nextCycle();
        doAccess("t6.recover", LW, 4'h0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 32'h0000_0600, 32'h0BAD_F00D);

        checkOutput("sb.empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
